// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer controller for the asynchronous FIFO.
// Tracks the read pointer and derives empty/occupancy from the synced write pointer.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH:0]   i_wptr_gray_sync,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_mem_rd_en,
   output logic [ADDR_WIDTH:0]   o_rptr_gray,
   output logic                  o_empty,
   output logic                  o_aempty,
   output logic [ADDR_WIDTH:0]   o_rd_count,
   output logic                  o_underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_next;
   logic [PW-1:0] rgray_next;
   logic [PW-1:0] wbin;
   logic [PW-1:0] count_next;
   logic          rd_fire;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign rd_fire     = i_rd_en & ~o_empty & ~i_rst;
   assign o_mem_rd_en = rd_fire;
   assign o_rd_addr   = rbin[ADDR_WIDTH-1:0];

   // Flags are computed from the post-edge pointers so a read and a
   // write-pointer change in the same cycle are both accounted for.
   assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, rd_fire};
   assign rgray_next = rbin_next ^ (rbin_next >> 1);
   assign wbin       = gray2bin(i_wptr_gray_sync);
   assign count_next = wbin - rbin_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rbin        <= '0;
         o_rptr_gray <= '0;
         o_empty     <= 1'b1;
         o_aempty    <= 1'b1;
         o_rd_count  <= '0;
         o_underflow <= 1'b0;
      end else begin
         rbin        <= rbin_next;
         o_rptr_gray <= rgray_next;
         o_empty     <= (rgray_next == i_wptr_gray_sync);
         o_aempty    <= (count_next <= AE_TH);
         o_rd_count  <= count_next;
         if (i_rd_en & o_empty) begin
            o_underflow <= 1'b1;
         end
      end
   end

endmodule
